// File: rtl/mul_arb.sv
// mul_arb: round-robin arbiter sharing one pipelined multiplier among NREQ requesters,
// with credit-based flow control into an in-order result FIFO.
module mul_arb #(
  parameter int NREQ = 4,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int LAT = 3,
  parameter int FIFO_D = 4,
  parameter int W = 1 + EXPO_W + MANT_W,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_rnd,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic [1:0]        mul_rnd,
  input  logic [W-1:0]      mul_res,
  input  logic [4:0]        mul_status,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_res,
  output logic [4:0]        rsp_status,
  output logic              busy
);
  localparam int PW = FIFO_D > 1 ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  logic [IDW-1:0] ptr, gnt, idx;
  logic gnt_v, credit_ok, xfer, push, pop;
  logic [LAT:0] tag_v;
  logic [IDW-1:0] tag_id [LAT+1];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] occ, cnt;
  logic [IDW-1:0] f_id [FIFO_D];
  logic [W-1:0] f_res [FIFO_D];
  logic [4:0] f_st [FIFO_D];

  // Descending scan so the candidate closest to ptr wins.
  always_comb begin
    gnt_v = 1'b0;
    gnt = ptr;
    idx = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt_v = 1'b1;
        gnt = idx;
      end
    end
  end

  assign credit_ok = cnt < CW'(FIFO_D);
  assign req_ready = (rst_n && gnt_v && credit_ok) ? NREQ'(1) << gnt : '0;
  assign xfer = |req_ready;
  assign push = tag_v[LAT];
  assign pop = rsp_valid && rsp_ready;
  assign rsp_valid = occ != '0;
  assign busy = cnt != '0;
  assign rsp_id = f_id[rp];
  assign rsp_res = f_res[rp];
  assign rsp_status = f_st[rp];

  // Tag stage 0 tracks the operand register; stage LAT lines up with mul_res.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      tag_v <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_rnd <= '0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], xfer};
      if (xfer) begin
        ptr <= gnt == IDW'(NREQ - 1) ? '0 : gnt + 1'b1;
        mul_a <= req_a[gnt*W +: W];
        mul_b <= req_b[gnt*W +: W];
        mul_rnd <= req_rnd[gnt*2 +: 2];
      end
      if (push) wp <= wp == PW'(FIFO_D - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(FIFO_D - 1) ? '0 : rp + 1'b1;
      occ <= occ + CW'(push) - CW'(pop);
      cnt <= cnt + CW'(xfer) - CW'(pop);
    end

  always_ff @(posedge clk) begin
    tag_id[0] <= gnt;
    for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
    if (push) begin
      f_id[wp] <= tag_id[LAT];
      f_res[wp] <= mul_res;
      f_st[wp] <= mul_status;
    end
  end
endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: directed and random checks of mul_arb against a queue-based reference model,
// with a behavioural LAT-cycle multiplier stub on the mul_* side.
module tb_mul_arb;
  localparam int N = 4, LAT = 3, FD = 4, W = 32;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*2-1:0] req_rnd;
  logic [W-1:0] mul_a, mul_b, mul_res, rsp_res;
  logic [1:0] mul_rnd, rsp_id;
  logic [4:0] mul_status, rsp_status;
  logic rsp_valid, rsp_ready, busy;

  mul_arb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
    .mul_res(mul_res), .mul_status(mul_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_status(rsp_status), .busy(busy)
  );

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [47:0] m;
    logic [9:0] e;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  function automatic logic [4:0] fst(logic [31:0] a, logic [31:0] b, logic [1:0] r);
    return {r, a[1] ^ b[1], a[0], b[0]};
  endfunction

  logic [W-1:0] pa [LAT];
  logic [W-1:0] pb [LAT];
  logic [1:0] pr [LAT];
  always @(posedge clk) begin
    pa[0] <= mul_a;
    pb[0] <= mul_b;
    pr[0] <= mul_rnd;
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign mul_res = fmul(pa[LAT-1], pb[LAT-1]);
  assign mul_status = fst(pa[LAT-1], pb[LAT-1], pr[LAT-1]);

  typedef struct {
    int id;
    logic [31:0] res;
    logic [4:0] st;
    int due;
  } op_t;
  op_t q[$];
  int ptr = 0, edges = 0, cmps = 0, errs = 0, dut_x = 0, dut_g = 0;
  logic dut_fire;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    cmps++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int grant();
    for (int k = 0; k < N; k++)
      if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic newop(int i);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = $urandom;
    req_b[i*W +: W] = $urandom;
    req_rnd[i*2 +: 2] = 2'($urandom_range(0, 3));
  endtask

  task automatic step();
    int g;
    logic [N-1:0] er;
    logic ev, pop;
    op_t o;
    #1;
    g = grant();
    er = (g >= 0 && q.size() < FD) ? N'(1) << g : '0;
    chk("req_ready", req_ready, er);
    chk("busy", busy, q.size() != 0);
    ev = q.size() != 0 && q[0].due <= edges;
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_res", rsp_res, q[0].res);
      chk("rsp_status", rsp_status, q[0].st);
    end
    dut_fire = |req_ready;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_g = i;
    if (dut_fire) dut_x++;
    pop = ev && rsp_ready;
    @(posedge clk);
    edges++;
    if (pop) void'(q.pop_front());
    if (er != 0) begin
      o.id = g;
      o.res = fmul(req_a[g*W +: W], req_b[g*W +: W]);
      o.st = fst(req_a[g*W +: W], req_b[g*W +: W], req_rnd[g*2 +: 2]);
      o.due = edges + LAT + 1;
      q.push_back(o);
      ptr = (g + 1) % N;
    end
    @(negedge clk);
    if (er != 0) req_valid[g] = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int c = 0; c < 80 && (req_valid != 0 || q.size() != 0); c++) step();
  endtask

  initial begin
    int nx, x0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_rnd = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_rnd", mul_rnd, 0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // single operation, fixed latency and value
    req_a[0 +: W] = 32'h40000000;
    req_b[0 +: W] = 32'h40400000;
    req_rnd[1:0] = 2'd0;
    req_valid[0] = 1'b1;
    step();
    repeat (4) step();
    #1;
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_res", rsp_res, 32'h40C00000);
    chk("single_status", rsp_status, 0);
    step();
    drain();

    // all requesters continuously valid: round-robin order
    nx = 1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) newop(i);
      step();
      if (dut_fire) begin
        chk("rr_order", dut_g, nx);
        nx = (nx + 1) % N;
      end
    end
    drain();

    // credit limit with consumer stalled
    rsp_ready = 1'b0;
    x0 = dut_x;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) newop(i);
      step();
    end
    chk("fill_xfers", dut_x - x0, FD);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    x0 = dut_x;
    repeat (4) step();
    chk("one_pop_one_xfer", dut_x - x0, 1);
    drain();

    // wrap-around grant with ptr=3
    newop(2);
    drain();
    newop(2);
    #1;
    chk("wrap_grant", req_ready, 4'b0100);
    step();
    newop(2);
    newop(3);
    #1;
    chk("ptr_after_wrap", req_ready, 4'b1000);
    drain();

    // reset with results in flight and buffered
    rsp_ready = 1'b0;
    newop(0);
    repeat (5) step();
    newop(1);
    newop(2);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    q.delete();
    ptr = 0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) step();

    // issue and pop on the same edge at count FD-1
    rsp_ready = 1'b0;
    newop(0);
    newop(1);
    newop(2);
    repeat (8) step();
    newop(3);
    rsp_ready = 1'b1;
    x0 = dut_x;
    step();
    chk("pop_issue_xfer", dut_x - x0, 1);
    rsp_ready = 1'b0;
    newop(0);
    newop(1);
    x0 = dut_x;
    repeat (4) step();
    chk("after_pop_issue", dut_x - x0, 1);
    drain();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(0, 1) == 1) newop(i);
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();
    #1;
    chk("final_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
